// File: rtl/pp_buf_pkg.sv
// Shared types and elaboration helpers for the ping-pong block buffer.
package pp_buf_pkg;

    typedef enum logic {
        FREE = 1'b0,
        FULL = 1'b1
    } bank_state_t;

    localparam int NBANKS = 2;

    // One entry of the read return pipeline: which bank was read and whether
    // the address was inside the bank (out-of-range reads return zero).
    typedef struct packed {
        logic vld;
        logic bank;
        logic inr;
    } rd_tag_t;

    function automatic bit rd_latency_ok(input int lat);
        return (lat == 1) || (lat == 2);
    endfunction

endpackage

// File: rtl/pp_block_buf_bank_ram.sv
// One dual-port bank: synchronous write, registered read, optional second
// output register when two cycles of read latency are configured.
module bank_ram #(
    parameter int LINES         = 64,
    parameter int ADDRESS_WIDTH = 6,
    parameter int WORD_WIDTH    = 12,
    parameter int RD_LATENCY    = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [ADDRESS_WIDTH-1:0] waddr,
    input  logic [WORD_WIDTH-1:0]    wdata,
    input  logic                     re,
    input  logic [ADDRESS_WIDTH-1:0] raddr,
    output logic [WORD_WIDTH-1:0]    rdata
);

    logic [WORD_WIDTH-1:0] mem [LINES];
    logic [WORD_WIDTH-1:0] rd1_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Output registers are reset so the top-level mux never sees X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd1_q <= '0;
        end else if (re) begin
            rd1_q <= mem[raddr];
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic [WORD_WIDTH-1:0] rd2_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd2_q <= '0;
            end else begin
                rd2_q <= rd1_q;
            end
        end
        assign rdata = rd2_q;
    end else begin : g_lat1
        assign rdata = rd1_q;
    end

endmodule

// File: rtl/pp_block_buf.sv
// Ping-pong block buffer: writer fills one bank while the reader randomly
// addresses the other; banks change hands through commit/release.
module pp_block_buf
    import pp_buf_pkg::*;
#(
    parameter int LINES         = 64,
    parameter int ADDRESS_WIDTH = 6,
    parameter int WORD_WIDTH    = 12,
    parameter int RD_LATENCY    = 1,
    parameter int AUTO_COMMIT   = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cs,
    input  logic                     wr,
    input  logic [ADDRESS_WIDTH-1:0] wr_add,
    input  logic [WORD_WIDTH-1:0]    wr_data,
    input  logic                     wr_last,
    output logic                     wr_ready,
    input  logic                     rd,
    input  logic [ADDRESS_WIDTH-1:0] rd_add,
    input  logic                     rd_last,
    output logic                     rd_avail,
    output logic [WORD_WIDTH-1:0]    rd_data,
    output logic                     rd_valid,
    output logic                     err_ovf,
    output logic                     err_unf,
    output logic                     wr_bank,
    output logic                     rd_bank
);

    if (!rd_latency_ok(RD_LATENCY)) begin : g_bad_latency
        $error("pp_block_buf: RD_LATENCY must be 1 or 2");
    end
    if (LINES > (2 ** ADDRESS_WIDTH)) begin : g_bad_lines
        $error("pp_block_buf: LINES exceeds address space");
    end

    localparam logic [ADDRESS_WIDTH:0]   LINES_W  = (ADDRESS_WIDTH + 1)'(LINES);
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADD = ADDRESS_WIDTH'(LINES - 1);

    bank_state_t [NBANKS-1:0] state_q, state_d;
    logic wr_bank_q, wr_bank_d;
    logic rd_bank_q, rd_bank_d;
    logic err_ovf_q, err_ovf_d;
    logic err_unf_q, err_unf_d;

    logic wr_in_range, rd_in_range;
    logic auto_last, commit, wr_acc;
    logic rd_acc, rd_release;

    assign wr_ready = (state_q[wr_bank_q] == FREE);
    assign rd_avail = (state_q[rd_bank_q] == FULL);

    assign wr_in_range = ({1'b0, wr_add} < LINES_W);
    assign rd_in_range = ({1'b0, rd_add} < LINES_W);

    assign auto_last  = (AUTO_COMMIT != 0) & wr & (wr_add == LAST_ADD);
    assign commit     = cs & wr_ready & (wr_last | auto_last);
    assign wr_acc     = cs & wr & wr_ready & wr_in_range;
    assign rd_acc     = cs & rd & rd_avail;
    assign rd_release = cs & rd_last & rd_avail;

    // Commit and release never target the same bank: the writer only holds
    // FREE banks and the reader only FULL ones.
    always_comb begin
        state_d   = state_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        err_ovf_d = err_ovf_q;
        err_unf_d = err_unf_q;
        if (commit) begin
            state_d[wr_bank_q] = FULL;
            wr_bank_d          = ~wr_bank_q;
        end
        if (rd_release) begin
            state_d[rd_bank_q] = FREE;
            rd_bank_d          = ~rd_bank_q;
        end
        if (cs && (wr || wr_last) && !wr_ready) begin
            err_ovf_d = 1'b1;
        end
        if (cs && (rd || rd_last) && !rd_avail) begin
            err_unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NBANKS; b++) begin
                state_q[b] <= FREE;
            end
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            err_ovf_q <= err_ovf_d;
            err_unf_q <= err_unf_d;
        end
    end

    assign wr_bank = wr_bank_q;
    assign rd_bank = rd_bank_q;
    assign err_ovf = err_ovf_q;
    assign err_unf = err_unf_q;

    logic [NBANKS-1:0][WORD_WIDTH-1:0] bank_rdata;

    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
        bank_ram #(
            .LINES         (LINES),
            .ADDRESS_WIDTH (ADDRESS_WIDTH),
            .WORD_WIDTH    (WORD_WIDTH),
            .RD_LATENCY    (RD_LATENCY)
        ) u_ram (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (wr_acc && (wr_bank_q == 1'(b))),
            .waddr (wr_add),
            .wdata (wr_data),
            .re    (rd_acc && rd_in_range && (rd_bank_q == 1'(b))),
            .raddr (rd_add),
            .rdata (bank_rdata[b])
        );
    end

    // The tag pipeline remembers the source bank, so a read issued in the
    // release cycle still returns data from the bank just handed back.
    rd_tag_t [RD_LATENCY-1:0] vld_pipe;
    rd_tag_t                  rd_tag;
    rd_tag_t                  rd_tail;
    logic [WORD_WIDTH-1:0]    rd_word;
    logic [WORD_WIDTH-1:0]    rd_hold_q;

    assign rd_tag = '{vld: rd_acc, bank: rd_bank_q, inr: rd_in_range};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= rd_tag;
            for (int s = 1; s < RD_LATENCY; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
            end
        end
    end

    assign rd_tail  = vld_pipe[RD_LATENCY-1];
    assign rd_word  = rd_tail.inr ? bank_rdata[rd_tail.bank] : '0;
    assign rd_valid = rd_tail.vld;
    assign rd_data  = rd_tail.vld ? rd_word : rd_hold_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_hold_q <= '0;
        end else if (rd_tail.vld) begin
            rd_hold_q <= rd_word;
        end
    end

endmodule

// File: tb/tb_pp_block_buf.sv
// Bench for pp_block_buf: two configurations driven in lockstep and checked
// every cycle against a block-level model, plus hand-computed spot checks.
module tb_pp_block_buf;

    localparam int LINES = 64;
    localparam int AW    = 6;
    localparam int WW    = 12;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          cs = 1'b0, wr = 1'b0, wr_last = 1'b0, rd = 1'b0, rd_last = 1'b0;
    logic [AW-1:0] wr_add = '0, rd_add = '0;
    logic [WW-1:0] wr_data = '0;

    logic [1:0]    wr_ready_w, rd_avail_w, rd_valid_w, err_ovf_w, err_unf_w, wr_bank_w, rd_bank_w;
    logic [WW-1:0] rd_data_w [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pp_block_buf #(.LINES(LINES), .ADDRESS_WIDTH(AW), .WORD_WIDTH(WW),
                   .RD_LATENCY(1), .AUTO_COMMIT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .cs(cs), .wr(wr), .wr_add(wr_add), .wr_data(wr_data),
        .wr_last(wr_last), .wr_ready(wr_ready_w[0]), .rd(rd), .rd_add(rd_add),
        .rd_last(rd_last), .rd_avail(rd_avail_w[0]), .rd_data(rd_data_w[0]),
        .rd_valid(rd_valid_w[0]), .err_ovf(err_ovf_w[0]), .err_unf(err_unf_w[0]),
        .wr_bank(wr_bank_w[0]), .rd_bank(rd_bank_w[0]));

    pp_block_buf #(.LINES(LINES), .ADDRESS_WIDTH(AW), .WORD_WIDTH(WW),
                   .RD_LATENCY(2), .AUTO_COMMIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .cs(cs), .wr(wr), .wr_add(wr_add), .wr_data(wr_data),
        .wr_last(wr_last), .wr_ready(wr_ready_w[1]), .rd(rd), .rd_add(rd_add),
        .rd_last(rd_last), .rd_avail(rd_avail_w[1]), .rd_data(rd_data_w[1]),
        .rd_valid(rd_valid_w[1]), .err_ovf(err_ovf_w[1]), .err_unf(err_unf_w[1]),
        .wr_bank(wr_bank_w[1]), .rd_bank(rd_bank_w[1]));

    // Model: instance i has read latency i+1 and auto-commit = i.
    logic [WW-1:0] m_mem [2][2][LINES];
    bit            m_full [2][2];
    bit            m_wb [2], m_rb [2], m_ovf [2], m_unf [2];
    logic [WW-1:0] m_last [2];
    logic [WW:0]   sched [2][256];   // {valid, data} due at a given edge count
    int unsigned   ecnt  = 0;
    bit            chk_en = 1'b0;
    logic [WW:0]   s_cur;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_full[i][0] = 1'b0; m_full[i][1] = 1'b0;
            m_wb[i] = 1'b0; m_rb[i] = 1'b0;
            m_ovf[i] = 1'b0; m_unf[i] = 1'b0;
            m_last[i] = '0;
            for (int k = 0; k < 256; k++) sched[i][k] = '0;
        end
    endtask

    task automatic model_step(input int i);
        bit wb, rb, wrdy, ravl;
        wb = m_wb[i]; rb = m_rb[i];
        wrdy = !m_full[i][wb];
        ravl = m_full[i][rb];
        if (!cs) return;
        if ((wr || wr_last) && !wrdy) m_ovf[i] = 1'b1;
        if ((rd || rd_last) && !ravl) m_unf[i] = 1'b1;
        if (rd && ravl) sched[i][8'(ecnt + i)] = {1'b1, m_mem[i][rb][rd_add]};
        if (wr && wrdy) m_mem[i][wb][wr_add] = wr_data;
        if (wrdy && (wr_last || (i == 1 && wr && wr_add == AW'(LINES - 1)))) begin
            m_full[i][wb] = 1'b1;
            m_wb[i] = !wb;
        end
        if (rd_last && ravl) begin
            m_full[i][rb] = 1'b0;
            m_rb[i] = !rb;
        end
    endtask

    always @(posedge clk) begin
        ecnt++;
        if (rst_n) begin
            for (int i = 0; i < 2; i++) model_step(i);
        end
    end

    task automatic cmp(input string nm, input int i, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d @edge %0d: got %h expected %h", nm, i, ecnt, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                s_cur = sched[i][8'(ecnt)];
                sched[i][8'(ecnt)] = '0;
                if (s_cur[WW]) m_last[i] = s_cur[WW-1:0];
                cmp("cyc_wr_ready", i, WW'(wr_ready_w[i]), WW'(!m_full[i][m_wb[i]]));
                cmp("cyc_rd_avail", i, WW'(rd_avail_w[i]), WW'(m_full[i][m_rb[i]]));
                cmp("cyc_wr_bank",  i, WW'(wr_bank_w[i]),  WW'(m_wb[i]));
                cmp("cyc_rd_bank",  i, WW'(rd_bank_w[i]),  WW'(m_rb[i]));
                cmp("cyc_err_ovf",  i, WW'(err_ovf_w[i]),  WW'(m_ovf[i]));
                cmp("cyc_err_unf",  i, WW'(err_unf_w[i]),  WW'(m_unf[i]));
                cmp("cyc_rd_valid", i, WW'(rd_valid_w[i]), WW'(s_cur[WW]));
                cmp("cyc_rd_data",  i, rd_data_w[i], m_last[i]);
            end
        end
    end

    task automatic chk(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cs = 1'b0; wr = 1'b0; wr_last = 1'b0; rd = 1'b0; rd_last = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        model_reset();
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic write_block(input logic [WW-1:0] base, input bit last);
        for (int a = 0; a < LINES; a++) begin
            cs = 1'b1; wr = 1'b1; wr_add = AW'(a); wr_data = base + WW'(a);
            wr_last = last && (a == LINES - 1);
            step();
        end
        idle();
    endtask

    task automatic read_block(input string nm, input logic [WW-1:0] exp5);
        for (int a = 0; a < LINES; a++) begin
            cs = 1'b1; rd = 1'b1; rd_add = AW'(a); rd_last = (a == LINES - 1);
            step();
            if (a == 5) begin
                chk({nm, "_valid5"}, WW'(rd_valid_w[0]), 12'h001);
                chk({nm, "_data5"}, rd_data_w[0], exp5);
            end
        end
        idle();
        step(); step();
    endtask

    initial begin
        #1;
        rst_n = 1'b0;
        model_reset();
        chk_en = 1'b1;
        step(); step();
        chk("rst_wr_bank", WW'(wr_bank_w[0]), 12'h000);
        chk("rst_rd_data", rd_data_w[0], 12'h000);
        chk("rst_wr_ready", WW'(wr_ready_w[0]), 12'h001);
        rst_n = 1'b1;
        step();

        // first block, committed on the last word
        write_block(12'h100, 1'b1);
        chk("blk1_wr_bank", WW'(wr_bank_w[0]), 12'h001);
        chk("blk1_rd_avail", WW'(rd_avail_w[0]), 12'h001);
        chk("blk1_wr_ready", WW'(wr_ready_w[0]), 12'h001);
        read_block("blk1", 12'h105);

        // read while empty
        do_reset();
        cs = 1'b1; rd = 1'b1; rd_add = AW'(3);
        step();
        idle();
        step();
        chk("unf_flag", WW'(err_unf_w[0]), 12'h001);
        chk("unf_valid", WW'(rd_valid_w[0]), 12'h000);
        chk("unf_data", rd_data_w[0], 12'h000);

        // overflow with both banks full
        do_reset();
        write_block(12'h200, 1'b1);
        write_block(12'h300, 1'b1);
        chk("ovf_wr_ready", WW'(wr_ready_w[0]), 12'h000);
        cs = 1'b1; wr = 1'b1; wr_add = '0; wr_data = 12'hABC;
        step();
        idle();
        chk("ovf_flag", WW'(err_ovf_w[0]), 12'h001);
        step(); step(); step();
        chk("ovf_sticky", WW'(err_ovf_w[0]), 12'h001);
        read_block("ovf", 12'h205);

        // streaming: commit and release land in the same cycle
        do_reset();
        write_block(12'h000, 1'b1);
        for (int b = 1; b <= 4; b++) begin
            for (int a = 0; a < LINES; a++) begin
                cs = 1'b1;
                wr = 1'b1; wr_add = AW'(a); wr_data = WW'(b * 256 + a); wr_last = (a == LINES - 1);
                rd = 1'b1; rd_add = AW'(a); rd_last = (a == LINES - 1);
                step();
            end
        end
        idle();
        step(); step();
        chk("str_ovf", WW'(err_ovf_w[0]), 12'h000);
        chk("str_unf", WW'(err_unf_w[0]), 12'h000);
        chk("str_wr_bank", WW'(wr_bank_w[0]), 12'h001);
        chk("str_rd_bank", WW'(rd_bank_w[0]), 12'h000);
        chk("str_unf_lat2", WW'(err_unf_w[1]), 12'h000);

        // auto-commit and two-cycle read latency
        do_reset();
        write_block(12'h500, 1'b0);
        chk("ac_wr_bank1", WW'(wr_bank_w[1]), 12'h001);
        chk("ac_rd_avail1", WW'(rd_avail_w[1]), 12'h001);
        chk("ac_wr_bank0", WW'(wr_bank_w[0]), 12'h000);
        chk("ac_rd_avail0", WW'(rd_avail_w[0]), 12'h000);
        cs = 1'b1; rd = 1'b1; rd_add = AW'(5);
        step();
        idle();
        chk("ac_valid_early", WW'(rd_valid_w[1]), 12'h000);
        step();
        chk("ac_valid", WW'(rd_valid_w[1]), 12'h001);
        chk("ac_data", rd_data_w[1], 12'h505);
        step();
        chk("ac_valid_after", WW'(rd_valid_w[1]), 12'h000);
        chk("ac_hold", rd_data_w[1], 12'h505);

        // reset in the middle of a fill, after raising an error flag
        do_reset();
        for (int a = 0; a <= 30; a++) begin
            cs = 1'b1; wr = 1'b1; wr_add = AW'(a); wr_data = WW'(12'h700 + a);
            rd = (a == 10);
            step();
        end
        chk("mid_unf_set", WW'(err_unf_w[0]), 12'h001);
        idle();
        rst_n = 1'b0;
        model_reset();
        step(); step();
        chk("mid_wr_bank", WW'(wr_bank_w[0]), 12'h000);
        chk("mid_rd_avail", WW'(rd_avail_w[0]), 12'h000);
        chk("mid_unf", WW'(err_unf_w[0]), 12'h000);
        chk("mid_valid", WW'(rd_valid_w[0]), 12'h000);
        rst_n = 1'b1;
        step();
        // chip select low blocks a commit
        cs = 1'b0; wr = 1'b1; wr_last = 1'b1;
        step();
        idle();
        chk("cs0_wr_bank", WW'(wr_bank_w[0]), 12'h000);
        write_block(12'h600, 1'b1);
        read_block("mid", 12'h605);

        step(); step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
